// File: rtl/ks_sum_32b.sv
// Final sum stage of a 32-bit Kogge-Stone adder with a valid/ready output skid buffer.
// Define KS_SAT_EN to clamp the stored sum on signed overflow.
module ks_sum_32b #(
    parameter int W_CNT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_c0,
    input  logic [31:0]      i_p_save,
    input  logic [31:0]      i_gk,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic [W_CNT-1:0] o_cnt
);

    logic [31:0]      raw_sum;
    logic [31:0]      res_sum;
    logic             res_cout;
    logic             res_ovf;
    logic             accept;
    logic             xfer;

    logic             out_vld_q,  out_vld_d;
    logic [31:0]      out_sum_q,  out_sum_d;
    logic             out_cout_q, out_cout_d;
    logic             out_ovf_q,  out_ovf_d;
    logic             skd_vld_q,  skd_vld_d;
    logic [31:0]      skd_sum_q,  skd_sum_d;
    logic             skd_cout_q, skd_cout_d;
    logic             skd_ovf_q,  skd_ovf_d;
    logic             rdy_q,      rdy_d;
    logic [W_CNT-1:0] cnt_q,      cnt_d;

    always_comb begin
        raw_sum       = '0;
        raw_sum[0]    = i_p_save[0] ^ i_c0;
        raw_sum[31:1] = i_p_save[31:1] ^ i_gk[30:0];
        res_cout      = i_gk[31];
        res_ovf       = i_gk[31] ^ i_gk[30];
`ifdef KS_SAT_EN
        if (res_ovf)
            res_sum = res_cout ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else
            res_sum = raw_sum;
`else
        res_sum = raw_sum;
`endif
    end

    assign accept = i_valid & rdy_q;
    assign xfer   = out_vld_q & i_ready;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_ovf_d  = out_ovf_q;
        skd_vld_d  = skd_vld_q;
        skd_sum_d  = skd_sum_q;
        skd_cout_d = skd_cout_q;
        skd_ovf_d  = skd_ovf_q;
        cnt_d      = cnt_q;

        if (xfer) begin
            cnt_d = cnt_q + W_CNT'(1);
            if (skd_vld_q) begin
                // Oldest entry advances; a same-cycle arrival queues behind it.
                out_sum_d  = skd_sum_q;
                out_cout_d = skd_cout_q;
                out_ovf_d  = skd_ovf_q;
                skd_vld_d  = accept;
                if (accept) begin
                    skd_sum_d  = res_sum;
                    skd_cout_d = res_cout;
                    skd_ovf_d  = res_ovf;
                end
            end else begin
                out_vld_d = accept;
                if (accept) begin
                    out_sum_d  = res_sum;
                    out_cout_d = res_cout;
                    out_ovf_d  = res_ovf;
                end
            end
        end else if (accept) begin
            if (!out_vld_q) begin
                out_vld_d  = 1'b1;
                out_sum_d  = res_sum;
                out_cout_d = res_cout;
                out_ovf_d  = res_ovf;
            end else begin
                skd_vld_d  = 1'b1;
                skd_sum_d  = res_sum;
                skd_cout_d = res_cout;
                skd_ovf_d  = res_ovf;
            end
        end

        rdy_d = ~skd_vld_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_vld_q  <= 1'b0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
            skd_vld_q  <= 1'b0;
            skd_sum_q  <= '0;
            skd_cout_q <= 1'b0;
            skd_ovf_q  <= 1'b0;
            rdy_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_ovf_q  <= out_ovf_d;
            skd_vld_q  <= skd_vld_d;
            skd_sum_q  <= skd_sum_d;
            skd_cout_q <= skd_cout_d;
            skd_ovf_q  <= skd_ovf_d;
            rdy_q      <= rdy_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_ready = rdy_q;
    assign o_valid = out_vld_q;
    assign o_sum   = out_sum_q;
    assign o_cout  = out_cout_q;
    assign o_ovf   = out_ovf_q;
    assign o_cnt   = cnt_q;

endmodule

// File: tb/tb_ks_sum_32b.sv
// Bench for ks_sum_32b: directed vector table, backpressure/counter/reset sequences,
// and random traffic against an arithmetic reference with an in-order scoreboard.
module tb_ks_sum_32b;

    localparam int W_CNT = 2;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic             i_c0 = 1'b0;
    logic [31:0]      i_p_save = '0;
    logic [31:0]      i_gk = '0;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [31:0]      o_sum;
    logic             o_cout;
    logic             o_ovf;
    logic [W_CNT-1:0] o_cnt;

    ks_sum_32b #(.W_CNT(W_CNT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_c0(i_c0), .i_p_save(i_p_save), .i_gk(i_gk), .o_valid(o_valid),
        .i_ready(i_ready), .o_sum(o_sum), .o_cout(o_cout), .o_ovf(o_ovf),
        .o_cnt(o_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c0;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]      cur_a = '0;
    logic [31:0]      cur_b = '0;
    logic             cur_c0 = 1'b0;
    res_t             sb_q[$];
    logic [W_CNT-1:0] exp_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Carry out of bit k is bit k+1 of the sum of the low k+1 operand bits plus c0.
    function automatic void prefix_ref(input logic [31:0] a, input logic [31:0] b, input logic c0,
                                       output logic [31:0] p, output logic [31:0] gk);
        logic [32:0] m;
        logic [32:0] s;
        p = a ^ b;
        gk = '0;
        for (int k = 0; k < 32; k++) begin
            m = (33'd1 << (k + 1)) - 33'd1;
            s = ({1'b0, a} & m) + ({1'b0, b} & m) + {32'd0, c0};
            gk[k] = s[k+1];
        end
    endfunction

    function automatic res_t add_ref(input logic [31:0] a, input logic [31:0] b, input logic c0);
        res_t r;
        logic [32:0] t;
        t = {1'b0, a} + {1'b0, b} + {32'd0, c0};
        r.cout = t[32];
        r.ovf  = (a[31] == b[31]) && (t[31] != a[31]);
        r.sum  = t[31:0];
`ifdef KS_SAT_EN
        if (r.ovf) r.sum = r.cout ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return r;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c0);
        logic [31:0] p;
        logic [31:0] gk;
        prefix_ref(a, b, c0, p, gk);
        cur_a = a; cur_b = b; cur_c0 = c0;
        i_p_save = p; i_gk = gk; i_c0 = c0;
        i_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic reset_dut();
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        #1 i_rst = 1'b0;
        tick();
    endtask

    // Handshakes seen at the falling edge are the ones the next rising edge commits.
    always @(negedge i_clk) begin
        res_t e;
        if (i_rst) begin
            sb_q.delete();
            exp_cnt = '0;
        end else begin
            check("cnt_track", 32'(o_cnt), 32'(exp_cnt));
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 32'(o_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_sum", o_sum, e.sum);
                    check("sb_cout", 32'(o_cout), 32'(e.cout));
                    check("sb_ovf", 32'(o_ovf), 32'(e.ovf));
                end
                exp_cnt = exp_cnt + 1'b1;
            end
            if (i_valid && o_ready) sb_q.push_back(add_ref(cur_a, cur_b, cur_c0));
        end
    end

    initial begin
        vec_t        tbl[7];
        res_t        ra, rb, rc;
        logic [1:0]  cnt_seq[5];
        logic [31:0] pick[6];
        logic [31:0] a, b;
        int          guard;

        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
`ifdef KS_SAT_EN
        tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        tbl[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 1'b1};
        tbl[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
`else
        tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 1'b1};
        tbl[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
`endif
        tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};

        cnt_seq[0] = 2'd1; cnt_seq[1] = 2'd2; cnt_seq[2] = 2'd3; cnt_seq[3] = 2'd0; cnt_seq[4] = 2'd1;
        pick[0] = 32'h0000_0000; pick[1] = 32'hFFFF_FFFF; pick[2] = 32'h7FFF_FFFF;
        pick[3] = 32'h8000_0000; pick[4] = 32'h0000_0001; pick[5] = 32'h5555_5555;

        #2;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_sum", o_sum, 32'd0);
        check("rst_cnt", 32'(o_cnt), 32'd0);
        @(negedge i_clk);
        #1 i_rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(o_ready), 32'd1);

        i_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].c0);
            tick();
            i_valid = 1'b0;
            check("vec_valid", 32'(o_valid), 32'd1);
            check("vec_sum", o_sum, tbl[i].sum);
            check("vec_cout", 32'(o_cout), 32'(tbl[i].cout));
            check("vec_ovf", 32'(o_ovf), 32'(tbl[i].ovf));
            tick();
        end

        reset_dut();
        ra = add_ref(32'h0000_0010, 32'h0000_0020, 1'b0);
        rb = add_ref(32'hFFFF_0000, 32'h0001_0000, 1'b1);
        rc = add_ref(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        i_ready = 1'b0;
        drive(32'h0000_0010, 32'h0000_0020, 1'b0);
        tick();
        check("bp_ready_1", 32'(o_ready), 32'd1);
        drive(32'hFFFF_0000, 32'h0001_0000, 1'b1);
        tick();
        check("bp_ready_0", 32'(o_ready), 32'd0);
        check("bp_hold_a", o_sum, ra.sum);
        drive(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        tick();
        tick();
        check("bp_still_0", 32'(o_ready), 32'd0);
        check("bp_stable_a", o_sum, ra.sum);
        check("bp_valid", 32'(o_valid), 32'd1);
        i_ready = 1'b1;
        tick();
        check("bp_out_b", o_sum, rb.sum);
        check("bp_ready_back", 32'(o_ready), 32'd1);
        check("bp_cnt1", 32'(o_cnt), 32'd1);
        tick();
        i_valid = 1'b0;
        check("bp_out_c", o_sum, rc.sum);
        check("bp_ovf_c", 32'(o_ovf), 32'(rc.ovf));
        check("bp_cnt2", 32'(o_cnt), 32'd2);
        tick();
        check("bp_cnt3", 32'(o_cnt), 32'd3);
        check("bp_empty", 32'(o_valid), 32'd0);

        reset_dut();
        i_ready = 1'b1;
        drive($urandom, $urandom, 1'($urandom));
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive($urandom, $urandom, 1'($urandom));
            else i_valid = 1'b0;
            tick();
            check("cnt_wrap", 32'(o_cnt), 32'(cnt_seq[i]));
        end

        i_ready = 1'b0;
        drive(32'h0000_0003, 32'h0000_0004, 1'b0);
        tick();
        drive(32'h0000_0005, 32'h0000_0006, 1'b0);
        tick();
        i_valid = 1'b0;
        check("full_ready", 32'(o_ready), 32'd0);
        #2 i_rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_cnt", 32'(o_cnt), 32'd0);
        check("mid_rst_ready", 32'(o_ready), 32'd0);
        check("mid_rst_sum", o_sum, 32'd0);
        @(negedge i_clk);
        #1 i_rst = 1'b0;
        check("pre_clk_ready", 32'(o_ready), 32'd0);
        tick();
        check("post_rst_ready", 32'(o_ready), 32'd1);
        check("post_rst_valid", 32'(o_valid), 32'd0);

        for (int i = 0; i < 400; i++) begin
            i_ready = ($urandom_range(3) != 0);
            if (!i_valid || o_ready) begin
                if ($urandom_range(4) != 0) begin
                    a = ($urandom_range(1) == 1) ? pick[$urandom_range(5)] : $urandom;
                    b = ($urandom_range(1) == 1) ? pick[$urandom_range(5)] : $urandom;
                    drive(a, b, 1'($urandom));
                end else begin
                    i_valid = 1'b0;
                end
            end
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        guard = 0;
        while (sb_q.size() != 0 && guard < 10) begin
            tick();
            guard++;
        end
        @(negedge i_clk);
        #1;
        check("drain_queue", 32'(sb_q.size()), 32'd0);
        check("drain_valid", 32'(o_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
